// File: rtl/axi_lite_cpu_arbiter.sv
// Two-master round-robin arbiter/sequencer for the AXI4-lite bridge CPU port.
// Issues one single-beat transaction at a time with a watchdog abort.
module axi_lite_cpu_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_wr_req,
  input  logic              m0_rd_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_wr_req,
  input  logic              m1_rd_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cpu_wr_en,
  output logic              cpu_rd_en,
  output logic [ADDR_W-1:0] cpu_wr_addr,
  output logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [DATA_W-1:0] cpu_wr_data,
  input  logic [DATA_W-1:0] cpu_rd_data,
  input  logic              cpu_wr_done,
  input  logic              cpu_rd_done,
  output logic              busy,
  output logic [1:0]        grant
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_n;
  logic              last;
  logic              owner;
  logic              is_wr;
  logic              aborted;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;

  logic req0, req1, any_req;
  logic pick, pick_wr;
  logic hit, expire;

  assign req0    = m0_wr_req | m0_rd_req;
  assign req1    = m1_wr_req | m1_rd_req;
  assign any_req = req0 | req1;

  // Prefer the requester that was not served last.
  assign pick    = last ? !req0 : req1;
  assign pick_wr = pick ? m1_wr_req : m0_wr_req;

  assign hit    = is_wr ? cpu_wr_done : cpu_rd_done;
  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   if (hit || expire) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      is_wr    <= 1'b0;
      aborted  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      grant    <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= pick;
            is_wr   <= pick_wr;
            addr_q  <= pick ? m1_addr : m0_addr;
            wdata_q <= pick ? m1_wdata : m0_wdata;
            grant   <= pick ? 2'b10 : 2'b01;
            m0_ack  <= !pick;
            m1_ack  <= pick;
            cnt     <= '0;
            aborted <= 1'b0;
          end
        end
        ISSUE: begin
          if (hit) begin
            aborted <= 1'b0;
            if (!is_wr) begin
              if (owner) m1_rdata <= cpu_rd_data;
              else       m0_rdata <= cpu_rd_data;
            end
          end else if (expire) begin
            aborted <= 1'b1;
            if (!is_wr) begin
              if (owner) m1_rdata <= '0;
              else       m0_rdata <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last  <= owner;
          cnt   <= '0;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

  logic wr_act, rd_act;

  assign wr_act = (state == ISSUE) && is_wr;
  assign rd_act = (state == ISSUE) && !is_wr;

  assign cpu_wr_en   = wr_act;
  assign cpu_rd_en   = rd_act;
  assign cpu_wr_addr = wr_act ? addr_q : '0;
  assign cpu_wr_data = wr_act ? wdata_q : '0;
  assign cpu_rd_addr = rd_act ? addr_q : '0;

  assign m0_done = (state == RESP) && !owner;
  assign m1_done = (state == RESP) && owner;
  assign m0_err  = m0_done && aborted;
  assign m1_err  = m1_done && aborted;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_cpu_arbiter.sv
// Self-checking bench for axi_lite_cpu_arbiter: directed and randomized
// transactions against a transaction-level expectation model.
module tb_axi_lite_cpu_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_wr_req, m0_rd_req, m1_wr_req, m1_rd_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_done, m0_err, m1_ack, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        cpu_wr_en, cpu_rd_en;
  logic [31:0] cpu_wr_addr, cpu_rd_addr, cpu_wr_data, cpu_rd_data;
  logic        cpu_wr_done, cpu_rd_done;
  logic        busy;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;
  int exp_last;
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  axi_lite_cpu_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_wr_req(m0_wr_req), .m0_rd_req(m0_rd_req),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_done(m0_done), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_wr_req(m1_wr_req), .m1_rd_req(m1_rd_req),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_done(m1_done), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .cpu_wr_addr(cpu_wr_addr), .cpu_rd_addr(cpu_rd_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_done(cpu_wr_done), .cpu_rd_done(cpu_rd_done),
    .busy(busy), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int m, input bit wr,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 1) begin
      m1_addr = a; m1_wdata = d;
      if (wr) m1_wr_req = 1'b1; else m1_rd_req = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = d;
      if (wr) m0_wr_req = 1'b1; else m0_rd_req = 1'b1;
    end
  endtask

  // Expected winner m; bridge answers on the lat-th enable cycle.
  task automatic do_txn(input int m, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rv,
                        input int lat, input bit stray);
    int n;
    int exp_n;
    bit exp_err;
    logic [1:0] oh;
    oh = (m == 1) ? 2'b10 : 2'b01;
    exp_n = (lat <= TO) ? lat : TO;
    exp_err = (lat > TO);
    cpu_rd_data = rv;
    @(negedge clk);
    chk("ack", {m1_ack, m0_ack}, oh);
    chk("grant", grant, oh);
    if (m == 1) begin
      if (wr) m1_wr_req = 1'b0; else m1_rd_req = 1'b0;
    end else begin
      if (wr) m0_wr_req = 1'b0; else m0_rd_req = 1'b0;
    end
    n = 0;
    while ((wr ? cpu_wr_en : cpu_rd_en) && n < 40) begin
      n++;
      chk("other_en", wr ? cpu_rd_en : cpu_wr_en, 0);
      if (wr) begin
        chk("wr_addr", cpu_wr_addr, a);
        chk("wr_data", cpu_wr_data, d);
        chk("rd_addr_idle", cpu_rd_addr, 0);
      end else begin
        chk("rd_addr", cpu_rd_addr, a);
        chk("wr_addr_idle", cpu_wr_addr, 0);
        chk("wr_data_idle", cpu_wr_data, 0);
      end
      if (stray && n == 1) begin
        if (wr) cpu_rd_done = 1'b1; else cpu_wr_done = 1'b1;
      end
      if (n == lat) begin
        if (wr) cpu_wr_done = 1'b1; else cpu_rd_done = 1'b1;
      end
      @(negedge clk);
      cpu_wr_done = 1'b0;
      cpu_rd_done = 1'b0;
    end
    chk("en_cycles", n, exp_n);
    if (!wr) exp_rd[m] = exp_err ? 32'h0 : rv;
    chk("done", {m1_done, m0_done}, oh);
    chk("err", {m1_err, m0_err}, exp_err ? oh : 2'b00);
    chk("rdata0", m0_rdata, exp_rd[0]);
    chk("rdata1", m1_rdata, exp_rd[1]);
    chk("resp_busy", busy, 1);
    @(negedge clk);
    chk("idle", {busy, grant, m1_done, m0_done, m1_ack, m0_ack}, 0);
    exp_last = m;
  endtask

  initial begin
    int first;
    int en_run;
    int idle_run;
    logic [1:0] prev_g;
    logic [1:0] gq [$];
    rst = 1'b1;
    {m0_wr_req, m0_rd_req, m1_wr_req, m1_rd_req} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    cpu_rd_data = '0; cpu_wr_done = 1'b0; cpu_rd_done = 1'b0;
    exp_last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;

    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, grant, cpu_wr_en, cpu_rd_en, m0_ack, m1_ack,
                       m0_done, m1_done, m0_err, m1_err}, 0);
    chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
    chk("reset_addr", {cpu_wr_addr, cpu_rd_addr}, 0);
    rst = 1'b0;

    // Directed transactions
    req(0, 1, 32'h0202_0202, 32'h0000_1111);
    do_txn(0, 1, 32'h0202_0202, 32'h0000_1111, 32'h0, 4, 0);
    req(1, 0, 32'h0202_0202, 32'h0);
    do_txn(1, 0, 32'h0202_0202, 32'h0, 32'h0000_1111, 3, 0);
    req(0, 0, 32'h0000_0040, 32'h0);
    do_txn(0, 0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1000, 0);
    req(1, 1, 32'h0000_0080, 32'hCAFE_F00D);
    do_txn(1, 1, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, 5, 1);
    req(0, 0, 32'h0000_00C0, 32'h0);
    do_txn(0, 0, 32'h0000_00C0, 32'h0, 32'h1234_5678, TO, 0);
    req(1, 1, 32'h0000_0100, 32'h5555_AAAA);
    do_txn(1, 1, 32'h0000_0100, 32'h5555_AAAA, 32'h0, TO + 1, 0);

    // Randomized single-requester transactions
    for (int i = 0; i < 16; i++) begin
      int m;
      bit wr;
      logic [31:0] a, d, rv;
      m = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; rv = $urandom;
      req(m, wr, a, d);
      do_txn(m, wr, a, d, rv, int'($urandom_range(1, TO + 3)),
             1'($urandom_range(0, 1)));
    end

    // Contention: both masters stream writes continuously
    first = (exp_last == 1) ? 0 : 1;
    req(0, 1, 32'h0000_1000, 32'h0000_000A);
    req(1, 1, 32'h0000_2000, 32'h0000_000B);
    prev_g = 2'b00; en_run = 0; idle_run = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cpu_wr_done = 1'b0;
      chk("excl_en", cpu_wr_en & cpu_rd_en, 0);
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (gq.size() > 0) chk("idle_gap", idle_run, 1);
        gq.push_back(grant);
        idle_run = 0;
        if (gq.size() == 4) begin
          m0_wr_req = 1'b0; m1_wr_req = 1'b0;
        end
      end
      prev_g = grant;
      if (!busy) idle_run++;
      if (cpu_wr_en) en_run++; else en_run = 0;
      cpu_wr_done = (en_run == 2);
      if (gq.size() == 4 && !busy) break;
    end
    cpu_wr_done = 1'b0;
    chk("n_grants", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++)
      chk("grant_seq", gq[i], ((first + i) % 2 == 1) ? 2'b10 : 2'b01);
    exp_last = (first + 3) % 2;
    @(negedge clk);

    // Reset in the middle of a read
    req(0, 0, 32'h0000_3000, 32'h0);
    @(negedge clk);
    chk("rst_ack", m0_ack, 1);
    m0_rd_req = 1'b0;
    @(negedge clk);
    chk("rst_en_before", cpu_rd_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_en_drop", {cpu_rd_en, cpu_rd_addr}, 0);
    chk("rst_busy", {busy, grant}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {m0_done, m1_done, m0_err, m1_err}, 0);
    end
    rst = 1'b0;
    exp_last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    req(0, 0, 32'h0000_4000, 32'h0);
    req(1, 1, 32'h0000_5000, 32'h0000_7777);
    do_txn(0, 0, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 2, 0);
    do_txn(1, 1, 32'h0000_5000, 32'h0000_7777, 32'h0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
